// File: rtl/map_hyp_ctrl_pkg.sv
// Shared types for the 4510 mapper hypervisor trap controller:
// state encoding, mapper byte indices and restore strobe order.
package map_hyp_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_SAVE0 = 4'd1,
    ST_SAVE1 = 4'd2,
    ST_SAVE2 = 4'd3,
    ST_SAVE3 = 4'd4,
    ST_ENTER = 4'd5,
    ST_HYP   = 4'd6,
    ST_RST0  = 4'd7,
    ST_RST1  = 4'd8,
    ST_RST2  = 4'd9,
    ST_RST3  = 4'd10,
    ST_EXIT  = 4'd11
  } state_e;

  localparam logic [1:0] MAP_SEL_OFF0_LO = 2'd0;
  localparam logic [1:0] MAP_SEL_OFF0_HI = 2'd1;
  localparam logic [1:0] MAP_SEL_OFF1_LO = 2'd2;
  localparam logic [1:0] MAP_SEL_OFF1_HI = 2'd3;

  // Strobe vector is {a, x, y, z}; byte n drives the n-th from the left.
  function automatic logic [3:0] rst_strobe(input logic [1:0] n);
    return 4'b1000 >> n;
  endfunction

endpackage

// File: rtl/map_hyp_ctrl_shadow_regs.sv
// 4x8 shadow file holding the mapper snapshot while the
// hypervisor runs; one write port, hyp and restore read ports.
module map_shadow_regs (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we_i,
  input  logic [1:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [1:0] raddr_i,
  output logic [7:0] rdata_o,
  input  logic [1:0] rsel_i,
  output logic [7:0] rsel_data_o
);

  logic [3:0][7:0] mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o     = mem_q[raddr_i];
  assign rsel_data_o = mem_q[rsel_i];

endmodule

// File: rtl/map_hyp_ctrl.sv
// Hypervisor trap controller: snapshots the mapper at trap entry,
// parks it during HYP, and replays the shadow bytes at exit.
module map_hyp_ctrl
  import map_hyp_ctrl_pkg::*;
#(
  parameter bit ENTRY_DISABLE = 1'b1,
  parameter bit EXIT_SYNC     = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ready,
  input  logic       sync,
  input  logic       map_busy,
  input  logic       trap_req,
  input  logic       exit_req,
  input  logic [7:0] map_reg,
  output logic [1:0] map_reg_sel,
  output logic       map_enable_ext,
  output logic       rst_load_a,
  output logic       rst_load_x,
  output logic       rst_load_y,
  output logic       rst_load_z,
  output logic [7:0] rst_data,
  output logic       hold,
  output logic       hyp_active,
  output logic       trap_ack,
  output logic       exit_ack,
  input  logic [1:0] shadow_sel,
  input  logic       shadow_we,
  input  logic [7:0] shadow_wdata,
  output logic [7:0] shadow_rdata
);

  state_e     state_q, state_d;
  logic       saving, restoring, parked;
  logic [1:0] idx;
  logic       trap_ok, exit_ok;
  logic       sh_we;
  logic [1:0] sh_waddr;
  logic [7:0] sh_wdata, sh_rst;

  assign trap_ok = trap_req && ready && sync && !map_busy;
  assign exit_ok = exit_req && (EXIT_SYNC ? (ready && sync) : 1'b1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (trap_ok) state_d = ST_SAVE0;
      ST_SAVE0: state_d = ST_SAVE1;
      ST_SAVE1: state_d = ST_SAVE2;
      ST_SAVE2: state_d = ST_SAVE3;
      ST_SAVE3: state_d = ST_ENTER;
      ST_ENTER: state_d = ST_HYP;
      ST_HYP:   if (exit_ok) state_d = ST_RST0;
      ST_RST0:  state_d = ST_RST1;
      ST_RST1:  state_d = ST_RST2;
      ST_RST2:  state_d = ST_RST3;
      ST_RST3:  state_d = ST_EXIT;
      ST_EXIT:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    saving    = 1'b0;
    restoring = 1'b0;
    idx       = MAP_SEL_OFF0_LO;
    unique case (state_q)
      ST_SAVE0: begin saving = 1'b1;    idx = MAP_SEL_OFF0_LO; end
      ST_SAVE1: begin saving = 1'b1;    idx = MAP_SEL_OFF0_HI; end
      ST_SAVE2: begin saving = 1'b1;    idx = MAP_SEL_OFF1_LO; end
      ST_SAVE3: begin saving = 1'b1;    idx = MAP_SEL_OFF1_HI; end
      ST_RST0:  begin restoring = 1'b1; idx = MAP_SEL_OFF0_LO; end
      ST_RST1:  begin restoring = 1'b1; idx = MAP_SEL_OFF0_HI; end
      ST_RST2:  begin restoring = 1'b1; idx = MAP_SEL_OFF1_LO; end
      ST_RST3:  begin restoring = 1'b1; idx = MAP_SEL_OFF1_HI; end
      default:  ;
    endcase
  end

  // Mapper stays parked from ENTER until the last restore byte lands.
  assign parked = (state_q == ST_ENTER) || (state_q == ST_HYP) || restoring;

  assign map_reg_sel    = saving ? idx : 2'd0;
  assign hold           = saving || restoring;
  assign hyp_active     = (state_q == ST_ENTER) || (state_q == ST_HYP);
  assign trap_ack       = (state_q == ST_ENTER);
  assign exit_ack       = (state_q == ST_EXIT);
  assign map_enable_ext = parked ? !ENTRY_DISABLE : 1'b1;

  assign {rst_load_a, rst_load_x, rst_load_y, rst_load_z} =
    restoring ? rst_strobe(idx) : 4'b0000;
  assign rst_data = restoring ? sh_rst : 8'h00;

  // SAVE capture owns the write port; hyp writes land only in HYP.
  assign sh_we    = saving || ((state_q == ST_HYP) && shadow_we);
  assign sh_waddr = saving ? idx : shadow_sel;
  assign sh_wdata = saving ? map_reg : shadow_wdata;

  map_shadow_regs u_shadow (
    .clk         (clk),
    .rst_n       (reset_n),
    .we_i        (sh_we),
    .waddr_i     (sh_waddr),
    .wdata_i     (sh_wdata),
    .raddr_i     (shadow_sel),
    .rdata_o     (shadow_rdata),
    .rsel_i      (idx),
    .rsel_data_o (sh_rst)
  );

endmodule

// File: tb/tb_map_hyp_ctrl.sv
// Self-checking bench for map_hyp_ctrl: emulated mapper plus a
// shadow/mapper byte model driven by trap/edit/exit events.
module tb_map_hyp_ctrl;

  localparam bit ED = 1'b1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ready, sync, map_busy, trap_req, exit_req;
  logic [7:0] map_reg;
  logic [1:0] map_reg_sel;
  logic       map_enable_ext;
  logic       rst_load_a, rst_load_x, rst_load_y, rst_load_z;
  logic [7:0] rst_data;
  logic       hold, hyp_active, trap_ack, exit_ack;
  logic [1:0] shadow_sel;
  logic       shadow_we;
  logic [7:0] shadow_wdata, shadow_rdata;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0][7:0] mb;
  logic [3:0][7:0] new_mb;
  logic            set_mb = 1'b0;
  logic [3:0][7:0] sh;

  logic [18:0] obs;
  logic [3:0]  lds;
  logic [18:0] IDLE_V;

  always #5 clk = ~clk;

  map_hyp_ctrl #(.ENTRY_DISABLE(ED), .EXIT_SYNC(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .ready(ready), .sync(sync),
    .map_busy(map_busy), .trap_req(trap_req), .exit_req(exit_req),
    .map_reg(map_reg), .map_reg_sel(map_reg_sel),
    .map_enable_ext(map_enable_ext),
    .rst_load_a(rst_load_a), .rst_load_x(rst_load_x),
    .rst_load_y(rst_load_y), .rst_load_z(rst_load_z),
    .rst_data(rst_data), .hold(hold), .hyp_active(hyp_active),
    .trap_ack(trap_ack), .exit_ack(exit_ack),
    .shadow_sel(shadow_sel), .shadow_we(shadow_we),
    .shadow_wdata(shadow_wdata), .shadow_rdata(shadow_rdata)
  );

  // Emulated mapper: readback by select, loads by restore strobes.
  assign map_reg = mb[map_reg_sel];
  always @(posedge clk) begin
    if (set_mb) mb <= new_mb;
    else begin
      if (rst_load_a) mb[0] <= rst_data;
      if (rst_load_x) mb[1] <= rst_data;
      if (rst_load_y) mb[2] <= rst_data;
      if (rst_load_z) mb[3] <= rst_data;
    end
  end

  assign lds = {rst_load_a, rst_load_x, rst_load_y, rst_load_z};
  always_comb begin
    obs = {map_reg_sel, hold, hyp_active, trap_ack, exit_ack,
           map_enable_ext, lds, (lds != 4'b0) ? rst_data : 8'h00};
  end

  function automatic logic [18:0] ev(
    input logic [1:0] sel, input logic h, input logic hy,
    input logic ta, input logic ea, input logic me,
    input logic [3:0] ld, input logic [7:0] d);
    return {sel, h, hy, ta, ea, me, ld, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mapper(input logic [3:0][7:0] b);
    new_mb = b;
    set_mb = 1'b1;
    step();
    set_mb = 1'b0;
  endtask

  task automatic check_shadow(input string nm);
    for (int s = 0; s < 4; s++) begin
      shadow_sel = s[1:0];
      #1;
      vectors++;
      if (shadow_rdata !== sh[s]) begin
        miscompares++;
        $display("FAIL %s sel=%0d got=%h want=%h", nm, s, shadow_rdata, sh[s]);
      end
    end
  endtask

  task automatic do_trap(input int busy, input int nsync, input bit save_wr);
    trap_req = 1'b1; ready = 1'b1; sync = 1'b1; map_busy = 1'b1;
    for (int i = 0; i < busy; i++) begin
      step();
      vectors++;
      if (obs !== IDLE_V) begin
        miscompares++;
        $display("FAIL trap_busy c%0d got=%h want=%h", i, obs, IDLE_V);
      end
    end
    map_busy = 1'b0;
    sync = 1'b0;
    for (int i = 0; i < nsync; i++) begin
      step();
      vectors++;
      if (obs !== IDLE_V) begin
        miscompares++;
        $display("FAIL trap_nosync c%0d got=%h want=%h", i, obs, IDLE_V);
      end
    end
    sync = 1'b1;
    step();
    trap_req = 1'b0;
    sync = 1'b0;
    ready = 1'($urandom_range(0, 1));
    for (int n = 0; n < 4; n++) begin
      shadow_we    = save_wr && (n == 2);
      shadow_sel   = 2'd2;
      shadow_wdata = ~mb[2];
      vectors++;
      if (obs !== ev(n[1:0], 1, 0, 0, 0, 1, 4'b0, 8'h0)) begin
        miscompares++;
        $display("FAIL save%0d got=%h want=%h", n, obs,
                 ev(n[1:0], 1, 0, 0, 0, 1, 4'b0, 8'h0));
      end
      step();
    end
    shadow_we = 1'b0;
    sh = mb;
    vectors++;
    if (obs !== ev(0, 0, 1, 1, 0, !ED, 4'b0, 8'h0)) begin
      miscompares++;
      $display("FAIL enter got=%h want=%h", obs,
               ev(0, 0, 1, 1, 0, !ED, 4'b0, 8'h0));
    end
    step();
    vectors++;
    if (obs !== ev(0, 0, 1, 0, 0, !ED, 4'b0, 8'h0)) begin
      miscompares++;
      $display("FAIL hyp got=%h want=%h", obs,
               ev(0, 0, 1, 0, 0, !ED, 4'b0, 8'h0));
    end
    check_shadow("snapshot");
  endtask

  task automatic do_exit(input int nsync, input bit wr,
                         input logic [1:0] wsel, input logic [7:0] wd);
    logic [18:0] hv;
    hv = ev(0, 0, 1, 0, 0, !ED, 4'b0, 8'h0);
    exit_req = 1'b1; trap_req = 1'b1; ready = 1'b0; sync = 1'b1;
    step();
    vectors++;
    if (obs !== hv) begin
      miscompares++;
      $display("FAIL exit_noready got=%h want=%h", obs, hv);
    end
    ready = 1'b1;
    sync = 1'b0;
    for (int i = 0; i < nsync; i++) begin
      step();
      vectors++;
      if (obs !== hv) begin
        miscompares++;
        $display("FAIL exit_nosync c%0d got=%h want=%h", i, obs, hv);
      end
    end
    sync = 1'b1;
    shadow_we = wr; shadow_sel = wsel; shadow_wdata = wd;
    if (wr) sh[wsel] = wd;
    step();
    exit_req = 1'b0; trap_req = 1'b0; shadow_we = 1'b0; sync = 1'b0;
    ready = 1'($urandom_range(0, 1));
    for (int n = 0; n < 4; n++) begin
      vectors++;
      if (obs !== ev(0, 1, 0, 0, 0, !ED, 4'b1000 >> n, sh[n])) begin
        miscompares++;
        $display("FAIL restore%0d got=%h want=%h", n, obs,
                 ev(0, 1, 0, 0, 0, !ED, 4'b1000 >> n, sh[n]));
      end
      step();
    end
    vectors++;
    if (obs !== ev(0, 0, 0, 0, 1, 1, 4'b0, 8'h0)) begin
      miscompares++;
      $display("FAIL exit got=%h want=%h", obs,
               ev(0, 0, 0, 0, 1, 1, 4'b0, 8'h0));
    end
    step();
    vectors++;
    if (obs !== IDLE_V) begin
      miscompares++;
      $display("FAIL post_exit got=%h want=%h", obs, IDLE_V);
    end
    for (int s = 0; s < 4; s++) begin
      vectors++;
      if (mb[s] !== sh[s]) begin
        miscompares++;
        $display("FAIL mapper_restored b%0d got=%h want=%h", s, mb[s], sh[s]);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (obs !== IDLE_V) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h want=%h", obs, IDLE_V);
    end
    sh = '0;
    check_shadow("reset_shadow");
    step();
    reset_n = 1'b1;
    step();
    vectors++;
    if (obs !== IDLE_V) begin
      miscompares++;
      $display("FAIL reset_release got=%h want=%h", obs, IDLE_V);
    end
  endtask

  task automatic test_trap_save();
    set_mapper({8'hB6, 8'h45, 8'hA3, 8'h12});
    do_trap(0, 0, 1'b0);
  endtask

  task automatic test_exit_edit();
    shadow_we = 1'b1; shadow_sel = 2'd1; shadow_wdata = 8'hF0;
    sh[1] = 8'hF0;
    step();
    shadow_we = 1'b0;
    check_shadow("hyp_write");
    do_exit(0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic test_busy_defer();
    do_trap(5, 0, 1'b0);
    do_exit(2, 1'b0, 2'd0, 8'h00);
    do_trap(2, 3, 1'b0);
    do_exit(0, 1'b1, 2'd3, 8'h5A);
  endtask

  task automatic test_write_gating();
    logic [1:0] s;
    s = 2'($urandom_range(0, 3));
    shadow_we = 1'b1; shadow_sel = s; shadow_wdata = ~sh[s];
    step();
    shadow_we = 1'b0;
    check_shadow("idle_write");
    set_mapper({8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)});
    do_trap(0, 1, 1'b1);
    do_exit(1, 1'b1, 2'($urandom_range(0, 3)), 8'($urandom));
  endtask

  task automatic test_reset_mid();
    logic [3:0][7:0] pre;
    set_mapper({8'h9C, 8'h27, 8'hE1, 8'h3D});
    do_trap(0, 0, 1'b0);
    pre = mb;
    for (int s = 0; s < 4; s++) begin
      shadow_we = 1'b1; shadow_sel = s[1:0]; shadow_wdata = ~pre[s];
      step();
    end
    shadow_we = 1'b0;
    exit_req = 1'b1; ready = 1'b1; sync = 1'b1;
    step();
    exit_req = 1'b0; sync = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    vectors++;
    if (obs !== IDLE_V) begin
      miscompares++;
      $display("FAIL mid_reset_out got=%h want=%h", obs, IDLE_V);
    end
    sh = '0;
    check_shadow("mid_reset_shadow");
    step();
    reset_n = 1'b1;
    step();
    vectors++;
    if (obs !== IDLE_V) begin
      miscompares++;
      $display("FAIL mid_reset_idle got=%h want=%h", obs, IDLE_V);
    end
    for (int s = 0; s < 4; s++) begin
      vectors++;
      if (mb[s] !== ((s == 0) ? ~pre[0] : pre[s])) begin
        miscompares++;
        $display("FAIL partial_restore b%0d got=%h want=%h", s, mb[s],
                 (s == 0) ? ~pre[0] : pre[s]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      set_mapper({8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)});
      do_trap($urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
      do_exit($urandom_range(0, 3), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 8'($urandom));
    end
  endtask

  initial begin
    IDLE_V = ev(0, 0, 0, 0, 0, 1, 4'b0, 8'h0);
    reset_n = 1'b0;
    ready = 1'b0; sync = 1'b0; map_busy = 1'b0;
    trap_req = 1'b0; exit_req = 1'b0;
    shadow_sel = 2'd0; shadow_we = 1'b0; shadow_wdata = 8'h00;
    mb = '0; new_mb = '0; sh = '0;
    test_reset();
    test_trap_save();
    test_exit_edit();
    test_busy_defer();
    test_write_gating();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
